// File: rtl/fetch_pkg.sv
// Shared widths, constants and the fetch sequencer state type.
package fetch_pkg;
  localparam int PC_W       = 10;
  localparam int INSTR_W    = 9;
  localparam int LUT_DEPTH  = 16;
  localparam int LUT_AW     = $clog2(LUT_DEPTH);
  localparam int IMEM_DEPTH = 1 << PC_W;

  localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;
endpackage

// File: rtl/jump_lut.sv
// Jump target/offset table: one write port, async read, async clear to zero.
module jump_lut
  import fetch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [LUT_AW-1:0] wr_addr,
  input  logic [PC_W-1:0]   wr_data,
  input  logic [LUT_AW-1:0] rd_addr,
  output logic [PC_W-1:0]   rd_data
);

  logic [PC_W-1:0] entries [LUT_DEPTH];

  // Entries clear on reset; writes land on the rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LUT_DEPTH; i++) entries[i] <= '0;
    end else if (wr_en) begin
      entries[wr_addr] <= wr_data;
    end
  end

  assign rd_data = entries[rd_addr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: IDLE -> RUN -> DONE, PC stepping and LUT jumps.
//
// Handshake: start is a single-cycle request with no ready; it is honoured in
// IDLE or DONE and ignored in RUN. pc_jmp_en/pc_jmp_abs/lut_pointer are
// same-cycle decoder responses to instr and are only consumed in RUN.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               pc_jmp_en,
  input  logic               pc_jmp_abs,
  input  logic [LUT_AW-1:0]  lut_pointer,
  input  logic               lut_wr_en,
  input  logic [LUT_AW-1:0]  lut_wr_addr,
  input  logic [PC_W-1:0]    lut_wr_data,
  input  logic               imem_wr_en,
  input  logic [PC_W-1:0]    imem_wr_addr,
  input  logic [INSTR_W-1:0] imem_wr_data,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc,
  output logic               instr_valid,
  output logic               done
);

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    lut_data;
  logic               halt;
  logic               wr_allowed;
  logic [INSTR_W-1:0] imem [IMEM_DEPTH];

  // Memories are only writable while the program is not executing.
  assign wr_allowed = (state_q != ST_RUN);
  assign instr      = imem[pc_q];
  assign halt       = (instr == HALT_INSTR);

  jump_lut u_jump_lut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (lut_wr_en && wr_allowed),
    .wr_addr (lut_wr_addr),
    .wr_data (lut_wr_data),
    .rd_addr (lut_pointer),
    .rd_data (lut_data)
  );

  // Instruction memory write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (imem_wr_en && wr_allowed) imem[imem_wr_addr] <= imem_wr_data;
  end

  // Next state and next PC; halt outranks a same-cycle jump, and the relative
  // add wraps naturally in PC_W bits (two's complement offset).
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          pc_d    = '0;
        end
      end
      ST_RUN: begin
        if (halt) begin
          state_d = ST_DONE;
        end else if (pc_jmp_en) begin
          pc_d = pc_jmp_abs ? lut_data : pc_q + lut_data;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  // State and PC registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign pc          = pc_q;
  assign instr_valid = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);

endmodule
